// File: rtl/vga_pkg.sv
// Shared VGA constants, colour codes, and rect_fill_writer types.
package vga_pkg;

   localparam int unsigned H_RES   = 640;
   localparam int unsigned V_RES   = 480;
   localparam int unsigned ADDR_W  = 19;
   localparam int unsigned COLOR_W = 3;
   localparam int unsigned X_W     = 10;
   localparam int unsigned Y_W     = 9;

   typedef enum logic [COLOR_W-1:0] {
      BLACK  = 3'd0,
      GREEN  = 3'd1,
      BLUE   = 3'd2,
      RED    = 3'd3,
      TEAL   = 3'd4,
      GRAY   = 3'd5,
      WHITE  = 3'd6,
      GWHITE = 3'd7
   } color_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLIP = 2'd1,
      ST_FILL = 2'd2
   } fill_state_e;

   typedef struct packed {
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic [X_W-1:0]     w;
      logic [Y_W-1:0]     h;
      logic [COLOR_W-1:0] color;
   } rect_cmd_t;

   // y*640 as shift-add (512 + 128); never needs a multiplier.
   function automatic logic [ADDR_W-1:0] row_base(input logic [Y_W-1:0] y);
      return (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7);
   endfunction

endpackage

// File: rtl/rect_fill_writer_if.sv
// Command and frame-buffer write bus between game logic and rect_fill_writer.
interface rect_fill_writer_if;
   import vga_pkg::*;

   logic               cmd_valid;
   logic               cmd_ready;
   logic [X_W-1:0]     cmd_x;
   logic [Y_W-1:0]     cmd_y;
   logic [X_W-1:0]     cmd_w;
   logic [Y_W-1:0]     cmd_h;
   logic [COLOR_W-1:0] cmd_color;
   logic               busy;
   logic               done;
   logic               fb_ready;
   logic               wr_en;
   logic [ADDR_W-1:0]  Waddr;
   logic [COLOR_W-1:0] Wdata;

   // Game logic / frame buffer side.
   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_ready,
      input  cmd_ready, busy, done, wr_en, Waddr, Wdata
   );

   // Fill writer side.
   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_ready,
      output cmd_ready, busy, done, wr_en, Waddr, Wdata
   );

endinterface

// File: rtl/fill_addr_gen.sv
// Raster-order address walker over a clipped rectangle; incremental adds only.
module fill_addr_gen
   import vga_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              advance_i,
   input  logic [X_W-1:0]    x0_i,
   input  logic [Y_W-1:0]    y0_i,
   input  logic [X_W-1:0]    x_end_i,
   input  logic [Y_W-1:0]    y_end_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o
);

   logic [X_W-1:0]    x_q, x0_q, x_end_q;
   logic [Y_W-1:0]    y_q, y_end_q;
   logic [ADDR_W-1:0] row_q, addr_q;
   logic              last_q;

   logic              x_at_end_c;
   logic [ADDR_W-1:0] row_next_c;
   logic [ADDR_W-1:0] row_load_c;

   // Row-wrap detection and next-row base.
   always_comb begin
      row_load_c = row_base(y0_i);
      row_next_c = row_q + ADDR_W'(H_RES);
      x_at_end_c = (x_q == x_end_q - X_W'(1));
   end

   // Counters; last_q flags that the pixel now presented is the final one.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_q     <= '0;
         x0_q    <= '0;
         x_end_q <= '0;
         y_q     <= '0;
         y_end_q <= '0;
         row_q   <= '0;
         addr_q  <= '0;
         last_q  <= 1'b0;
      end else if (load_i) begin
         x_q     <= x0_i;
         x0_q    <= x0_i;
         x_end_q <= x_end_i;
         y_q     <= y0_i;
         y_end_q <= y_end_i;
         row_q   <= row_load_c;
         addr_q  <= row_load_c + ADDR_W'(x0_i);
         last_q  <= (x0_i + X_W'(1) == x_end_i) && (y0_i + Y_W'(1) == y_end_i);
      end else if (advance_i) begin
         if (x_at_end_c) begin
            x_q    <= x0_q;
            y_q    <= y_q + Y_W'(1);
            row_q  <= row_next_c;
            addr_q <= row_next_c + ADDR_W'(x0_q);
            last_q <= (x0_q + X_W'(1) == x_end_q) && (y_q + Y_W'(2) == y_end_q);
         end else begin
            x_q    <= x_q + X_W'(1);
            addr_q <= addr_q + ADDR_W'(1);
            last_q <= (x_q + X_W'(2) == x_end_q) && (y_q + Y_W'(1) == y_end_q);
         end
      end
   end

   assign addr_o = addr_q;
   assign last_o = last_q;

endmodule

// File: rtl/rect_fill_writer.sv
// Rectangle fill engine: accepts a command, clips to the screen, writes one pixel per cycle.
module rect_fill_writer
   import vga_pkg::*;
(
   input  logic            clk_100mhz,
   input  logic            rst,
   rect_fill_writer_if.slave bus
);

   fill_state_e state_q;
   rect_cmd_t   cmd_q;
   logic        cmd_ready_q;
   logic        busy_q;
   logic        done_q;
   logic        wr_en_q;

   logic [X_W:0]      x_sum_c;
   logic [Y_W:0]      y_sum_c;
   logic [X_W-1:0]    x_end_c;
   logic [Y_W-1:0]    y_end_c;
   logic              empty_c;
   logic              load_c;
   logic              advance_c;
   logic              last;
   logic [ADDR_W-1:0] addr;

   // Clip the captured rectangle to the visible area; widened sums cannot overflow.
   always_comb begin
      x_sum_c = (X_W+1)'(cmd_q.x) + (X_W+1)'(cmd_q.w);
      y_sum_c = (Y_W+1)'(cmd_q.y) + (Y_W+1)'(cmd_q.h);
      x_end_c = (x_sum_c > (X_W+1)'(H_RES)) ? X_W'(H_RES) : x_sum_c[X_W-1:0];
      y_end_c = (y_sum_c > (Y_W+1)'(V_RES)) ? Y_W'(V_RES) : y_sum_c[Y_W-1:0];
      empty_c = (cmd_q.w == '0) || (cmd_q.h == '0) ||
                (cmd_q.x >= X_W'(H_RES)) || (cmd_q.y >= Y_W'(V_RES));
   end

   // Address generator controls: load on a non-empty CLIP, step on each accepted non-final write.
   always_comb begin
      load_c    = (state_q == ST_CLIP) && !empty_c;
      advance_c = (state_q == ST_FILL) && bus.fb_ready && !last;
   end

   // Command FSM with registered handshake and status outputs.
   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wr_en_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  cmd_q       <= '{x: bus.cmd_x, y: bus.cmd_y, w: bus.cmd_w,
                                   h: bus.cmd_h, color: bus.cmd_color};
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= ST_CLIP;
               end
            end
            ST_CLIP: begin
               if (empty_c) begin
                  done_q      <= 1'b1;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  wr_en_q <= 1'b1;
                  state_q <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (bus.fb_ready && last) begin
                  wr_en_q     <= 1'b0;
                  done_q      <= 1'b1;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   fill_addr_gen u_addr_gen (
      .clk_i     (clk_100mhz),
      .rst_i     (rst),
      .load_i    (load_c),
      .advance_i (advance_c),
      .x0_i      (cmd_q.x),
      .y0_i      (cmd_q.y),
      .x_end_i   (x_end_c),
      .y_end_i   (y_end_c),
      .addr_o    (addr),
      .last_o    (last)
   );

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.Waddr     = addr;
   assign bus.Wdata     = cmd_q.color;

endmodule

// File: tb/tb_rect_fill_writer.sv
// Self-checking bench for rect_fill_writer.
module tb_rect_fill_writer;
   import vga_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rect_fill_writer_if bus();

   rect_fill_writer dut (
      .clk_100mhz (clk),
      .rst        (rst),
      .bus        (bus)
   );

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int fb_mode = 0;   // 0: always ready, 1: random stalls, 2: follow fb_manual
   bit fb_manual = 1'b1;

   int addr_log[$];
   int data_log[$];
   int wcyc_log[$];
   int done_log[$];

   bit prev_stall = 1'b0;
   int prev_addr  = 0;
   int prev_data  = 0;

   typedef struct {
      int x, y, w, h, c;
      int exp_n, exp_first, exp_last;
   } vec_t;

   function automatic void chk(input bit ok, input string nm, input string detail);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: %s", nm, detail);
   endfunction

   function automatic void clear_logs();
      addr_log.delete();
      data_log.delete();
      wcyc_log.delete();
      done_log.delete();
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Frame buffer ready driver.
   initial begin
      bus.fb_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (fb_mode == 0)      bus.fb_ready = 1'b1;
         else if (fb_mode == 1) bus.fb_ready = ($urandom_range(0, 3) != 0);
         else                   bus.fb_ready = fb_manual;
      end
   end

   // Monitor: log accepted writes and done pulses, check stall stability.
   always @(negedge clk) begin
      if (prev_stall)
         chk(bus.wr_en && int'(bus.Waddr) == prev_addr && int'(bus.Wdata) == prev_data,
             "stall_hold", $sformatf("wr_en=%0d addr=%0d data=%0d, want 1/%0d/%0d",
                                     bus.wr_en, bus.Waddr, bus.Wdata, prev_addr, prev_data));
      prev_stall = bus.wr_en && !bus.fb_ready;
      prev_addr  = int'(bus.Waddr);
      prev_data  = int'(bus.Wdata);
      if (bus.wr_en && bus.fb_ready) begin
         addr_log.push_back(int'(bus.Waddr));
         data_log.push_back(int'(bus.Wdata));
         wcyc_log.push_back(cyc);
      end
      if (bus.done) begin
         done_log.push_back(cyc);
         chk(bus.cmd_ready && !bus.busy, "done_ready",
             $sformatf("cmd_ready=%0d busy=%0d at done, want 1/0", bus.cmd_ready, bus.busy));
      end
   end

   task automatic send_cmd(input int x, input int y, input int w, input int h, input int c,
                           output int acc);
      @(posedge clk);
      #1;
      bus.cmd_x     = X_W'(x);
      bus.cmd_y     = Y_W'(y);
      bus.cmd_w     = X_W'(w);
      bus.cmd_h     = Y_W'(h);
      bus.cmd_color = COLOR_W'(c);
      bus.cmd_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         #1;
         if (bus.cmd_ready) begin
            acc = cyc + 1;
            clear_logs();
            break;
         end
      end
      if (acc < 0) chk(bus.cmd_ready, "accept_timeout", "cmd_ready never rose, want 1");
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_x     = X_W'($urandom);
      bus.cmd_y     = Y_W'($urandom);
      bus.cmd_w     = X_W'($urandom);
      bus.cmd_h     = Y_W'($urandom);
      bus.cmd_color = COLOR_W'($urandom);
   endtask

   task automatic wait_done(input int budget, input string nm, output int dcyc);
      dcyc = -1;
      for (int i = 0; i < budget; i++) begin
         if (done_log.size() > 0) begin
            dcyc = done_log[0];
            break;
         end
         @(negedge clk);
         #1;
      end
      if (dcyc < 0)
         chk(done_log.size() > 0, {nm, ":done_timeout"},
             $sformatf("no done within %0d cycles, want one", budget));
   endtask

   // Reference: every on-screen pixel of the rectangle in raster order, plus timing rules.
   task automatic check_result(input string nm, input int x, input int y, input int w,
                               input int h, input int c, input int acc, input bit timed,
                               input bit settle);
      int exp_q[$];
      int n, dcyc, bad;
      bit ok;
      if (w > 0 && h > 0 && x < int'(H_RES) && y < int'(V_RES)) begin
         int xe, ye;
         xe = (x + w > int'(H_RES)) ? int'(H_RES) : x + w;
         ye = (y + h > int'(V_RES)) ? int'(V_RES) : y + h;
         for (int yy = y; yy < ye; yy++)
            for (int xx = x; xx < xe; xx++)
               exp_q.push_back(yy * int'(H_RES) + xx);
      end
      n = exp_q.size();
      wait_done(n * 8 + 64, nm, dcyc);
      if (settle) begin
         repeat (3) @(negedge clk);
         #1;
      end
      chk(addr_log.size() == n, {nm, ":count"},
          $sformatf("got %0d writes, want %0d", addr_log.size(), n));
      if (n > 0) begin
         ok = 1'b1;
         bad = -1;
         for (int i = 0; i < n && i < addr_log.size(); i++)
            if (addr_log[i] != exp_q[i]) begin
               ok = 1'b0;
               bad = i;
               break;
            end
         chk(ok, {nm, ":addr_seq"}, $sformatf("index %0d got %0d want %0d", bad,
             (bad >= 0) ? addr_log[bad] : 0, (bad >= 0) ? exp_q[bad] : 0));
         ok = 1'b1;
         foreach (data_log[i]) if (data_log[i] != c) ok = 1'b0;
         chk(ok, {nm, ":wdata"}, $sformatf("first data %0d, want %0d for all",
             (data_log.size() > 0) ? data_log[0] : -1, c));
      end
      chk(done_log.size() == 1, {nm, ":done_once"},
          $sformatf("got %0d done pulses, want 1", done_log.size()));
      if (timed && dcyc >= 0) begin
         chk(dcyc == acc + n + 1, {nm, ":done_latency"},
             $sformatf("done at cycle %0d, want %0d", dcyc, acc + n + 1));
         if (n > 0 && wcyc_log.size() > 0)
            chk(wcyc_log[0] == acc + 1, {nm, ":first_write_latency"},
                $sformatf("first write at cycle %0d, want %0d", wcyc_log[0], acc + 1));
      end
   endtask

   // Watchdog: the run must end on its own.
   initial begin
      #20000000;
      $display("FAIL watchdog: simulation exceeded time limit, want $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[9];
      int acc, acc_b, x, y, w, h, c;

      vecs[0] = '{x:0,   y:0,   w:2,  h:2, c:3, exp_n:4,  exp_first:0,      exp_last:641};
      vecs[1] = '{x:638, y:478, w:4,  h:4, c:5, exp_n:4,  exp_first:306558, exp_last:307199};
      vecs[2] = '{x:5,   y:5,   w:0,  h:3, c:1, exp_n:0,  exp_first:0,      exp_last:0};
      vecs[3] = '{x:700, y:5,   w:4,  h:3, c:2, exp_n:0,  exp_first:0,      exp_last:0};
      vecs[4] = '{x:5,   y:5,   w:4,  h:0, c:4, exp_n:0,  exp_first:0,      exp_last:0};
      vecs[5] = '{x:3,   y:480, w:5,  h:5, c:6, exp_n:0,  exp_first:0,      exp_last:0};
      vecs[6] = '{x:639, y:479, w:1,  h:1, c:7, exp_n:1,  exp_first:307199, exp_last:307199};
      vecs[7] = '{x:100, y:200, w:10, h:3, c:7, exp_n:30, exp_first:128100, exp_last:129389};
      vecs[8] = '{x:10,  y:5,   w:3,  h:1, c:2, exp_n:3,  exp_first:3210,   exp_last:3212};

      rst = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_x = '0;
      bus.cmd_y = '0;
      bus.cmd_w = '0;
      bus.cmd_h = '0;
      bus.cmd_color = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk(bus.cmd_ready == 1'b1, "rst:cmd_ready", $sformatf("got %0d want 1", bus.cmd_ready));
      chk(bus.wr_en == 1'b0, "rst:wr_en", $sformatf("got %0d want 0", bus.wr_en));
      chk(bus.done == 1'b0, "rst:done", $sformatf("got %0d want 0", bus.done));
      chk(bus.busy == 1'b0, "rst:busy", $sformatf("got %0d want 0", bus.busy));
      chk(bus.Waddr == '0, "rst:waddr", $sformatf("got %0d want 0", bus.Waddr));
      chk(bus.Wdata == '0, "rst:wdata", $sformatf("got %0d want 0", bus.Wdata));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk(bus.cmd_ready == 1'b1, "post_rst:cmd_ready", $sformatf("got %0d want 1", bus.cmd_ready));

      // Directed table
      for (int i = 0; i < 9; i++) begin
         send_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c, acc);
         check_result($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h,
                      vecs[i].c, acc, 1'b1, 1'b1);
         chk(addr_log.size() == vecs[i].exp_n, $sformatf("vec%0d:tbl_count", i),
             $sformatf("got %0d want %0d", addr_log.size(), vecs[i].exp_n));
         if (vecs[i].exp_n > 0 && addr_log.size() > 0) begin
            chk(addr_log[0] == vecs[i].exp_first, $sformatf("vec%0d:tbl_first", i),
                $sformatf("got %0d want %0d", addr_log[0], vecs[i].exp_first));
            chk(addr_log[addr_log.size()-1] == vecs[i].exp_last, $sformatf("vec%0d:tbl_last", i),
                $sformatf("got %0d want %0d", addr_log[addr_log.size()-1], vecs[i].exp_last));
         end
      end

      // Stall: 3x1 at (10,5), second pixel held off for three cycles
      fb_manual = 1'b1;
      fb_mode = 2;
      send_cmd(10, 5, 3, 1, 2, acc);
      @(negedge clk);
      #1;
      @(negedge clk);
      #1;
      chk(bus.wr_en && bus.Waddr == 19'd3210, "stall:first",
          $sformatf("wr_en=%0d addr=%0d, want 1/3210", bus.wr_en, bus.Waddr));
      fb_manual = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk(bus.wr_en && !bus.fb_ready && bus.Waddr == 19'd3211, $sformatf("stall:hold%0d", k),
             $sformatf("wr_en=%0d fb_ready=%0d addr=%0d, want 1/0/3211",
                       bus.wr_en, bus.fb_ready, bus.Waddr));
      end
      fb_manual = 1'b1;
      check_result("stall", 10, 5, 3, 1, 2, acc, 1'b0, 1'b1);
      fb_mode = 0;

      // Back-to-back: second command accepted in the done cycle of the first
      send_cmd(5, 7, 3, 2, 4, acc);
      bus.cmd_x = 10'd20;
      bus.cmd_y = 9'd30;
      bus.cmd_w = 10'd2;
      bus.cmd_h = 9'd1;
      bus.cmd_color = 3'd1;
      bus.cmd_valid = 1'b1;
      check_result("b2b_a", 5, 7, 3, 2, 4, acc, 1'b1, 1'b0);
      chk(bus.done && bus.cmd_ready, "b2b:accept_window",
          $sformatf("done=%0d cmd_ready=%0d, want 1/1", bus.done, bus.cmd_ready));
      acc_b = cyc + 1;
      clear_logs();
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      check_result("b2b_b", 20, 30, 2, 1, 1, acc_b, 1'b1, 1'b1);

      // Reset during a full-screen clear, then a 1x1 command
      send_cmd(0, 0, 640, 480, 0, acc);
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         #1;
         if (addr_log.size() >= 5) break;
      end
      chk(addr_log.size() == 5 && addr_log[0] == 0 && addr_log[4] == 4, "clear:prefix",
          $sformatf("got %0d writes ending %0d, want 5 ending 4", addr_log.size(),
                    (addr_log.size() > 0) ? addr_log[addr_log.size()-1] : -1));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk(!bus.wr_en, "abort:wr_en", $sformatf("got %0d want 0", bus.wr_en));
      chk(!bus.busy, "abort:busy", $sformatf("got %0d want 0", bus.busy));
      chk(bus.cmd_ready, "abort:cmd_ready", $sformatf("got %0d want 1", bus.cmd_ready));
      chk(!bus.done, "abort:done", $sformatf("got %0d want 0", bus.done));
      repeat (5) @(negedge clk);
      #1;
      chk(addr_log.size() == 5 && done_log.size() == 0, "abort:quiet",
          $sformatf("writes=%0d dones=%0d, want 5/0", addr_log.size(), done_log.size()));
      send_cmd(1, 1, 1, 1, 5, acc);
      check_result("after_abort", 1, 1, 1, 1, 5, acc, 1'b1, 1'b1);
      chk(addr_log.size() == 1 && addr_log[0] == 641, "after_abort:addr",
          $sformatf("got %0d writes first %0d, want 1 at 641", addr_log.size(),
                    (addr_log.size() > 0) ? addr_log[0] : -1));

      // Bottom band clipped at the last line
      send_cmd(0, 420, 640, 100, 6, acc);
      check_result("band", 0, 420, 640, 100, 6, acc, 1'b1, 1'b1);
      chk(addr_log.size() == 38400 && addr_log[addr_log.size()-1] == 307199, "band:last",
          $sformatf("got %0d writes last %0d, want 38400 last 307199", addr_log.size(),
                    (addr_log.size() > 0) ? addr_log[addr_log.size()-1] : -1));

      // Randomized commands against the reference, alternating clean and stalled ready
      for (int i = 0; i < 40; i++) begin
         fb_mode = i % 2;
         x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(600, 700)) : int'($urandom_range(0, 639));
         y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(440, 500)) : int'($urandom_range(0, 479));
         w = int'($urandom_range(0, 40));
         h = int'($urandom_range(0, 8));
         c = int'($urandom_range(0, 7));
         send_cmd(x, y, w, h, c, acc);
         check_result($sformatf("rnd%0d", i), x, y, w, h, c, acc, fb_mode == 0, 1'b1);
      end
      fb_mode = 0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
